// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, line levels and parity convention.
// Used by both the receiver and the transmitter so both ends agree on the frame.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  // 1'b0 selects even parity: the parity bit makes the total count of ones even.
  localparam logic PARITY_ODD = 1'b0;
  localparam int   MAX_WIDTH  = 64;

  function automatic logic parity_of(input logic [MAX_WIDTH-1:0] d);
    return (^d) ^ PARITY_ODD;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the serial line; resets to the idle (high) level
// so that reset never looks like a start bit.
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  // Metastability filter: async_i reaches sync_o two clocks later.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= IDLE_LEVEL;
      sync_q <= IDLE_LEVEL;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start qualification, mid-bit sampling, even-parity and stop
// checking, with a one-cycle valid strobe and held error flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  output logic             parity_err,
  output logic             frame_err,
  output logic             busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] HALF_C   = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST_C   = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);

  logic             rx_s;
  uart_state_e      state_q;
  logic [CW-1:0]    cnt_q;
  logic [IW-1:0]    idx_q;
  logic [WIDTH-1:0] shift_q;
  logic             par_q;
  logic             armed_q;
  logic [WIDTH-1:0] data_out_q;
  logic             valid_q;
  logic             parity_err_q;
  logic             frame_err_q;
  logic             busy_q;

  uart_rx_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (rx_in),
    .sync_o  (rx_s)
  );

  // Receive FSM with bit timing and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      armed_q      <= 1'b0;
      data_out_q   <= '0;
      valid_q      <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (rx_s == IDLE_LEVEL) begin
        armed_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          // The detect cycle is cnt 0 of the start bit; an unarmed line stuck low is ignored.
          if (armed_q && rx_s == START_BIT) begin
            busy_q <= 1'b1;
            idx_q  <= '0;
            if (CLKS_PER_BIT == 1) begin
              state_q <= DATA;
              cnt_q   <= '0;
            end else begin
              state_q <= START;
              cnt_q   <= CW'(1);
            end
          end
        end
        START: begin
          if (cnt_q == HALF_C && rx_s == IDLE_LEVEL) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else if (cnt_q == LAST_C) begin
            state_q <= DATA;
            cnt_q   <= '0;
            idx_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DATA: begin
          if (cnt_q == HALF_C) begin
            shift_q <= WIDTH'({rx_s, shift_q} >> 1);
          end
          if (cnt_q == LAST_C) begin
            cnt_q <= '0;
            if (idx_q == IDX_LAST) begin
              state_q <= PARITY;
            end else begin
              idx_q <= idx_q + IW'(1);
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        PARITY: begin
          if (cnt_q == HALF_C) begin
            par_q <= rx_s;
          end
          if (cnt_q == LAST_C) begin
            state_q <= STOP;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        STOP: begin
          // Leave at mid-stop so a back-to-back start edge is never missed.
          if (cnt_q == HALF_C) begin
            data_out_q   <= shift_q;
            parity_err_q <= (par_q != parity_of(MAX_WIDTH'(shift_q)));
            frame_err_q  <= (rx_s != STOP_BIT);
            valid_q      <= 1'b1;
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            cnt_q        <= '0;
            if (rx_s != STOP_BIT) begin
              armed_q <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign data_out   = data_out_q;
  assign valid      = valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at CLKS_PER_BIT 1, 4 and 16,
// with the serial transmitter modelled by the bench itself.
module tb_uart_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic rx_line;

  logic [7:0] d1, d4, d16;
  logic v1, v4, v16, pe1, pe4, pe16, fe1, fe4, fe16, b1, b4, b16;

  uart_rx #(.WIDTH(8), .CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst(rst), .rx_in(rx_line), .data_out(d1), .valid(v1),
    .parity_err(pe1), .frame_err(fe1), .busy(b1));
  uart_rx #(.WIDTH(8), .CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rst(rst), .rx_in(rx_line), .data_out(d4), .valid(v4),
    .parity_err(pe4), .frame_err(fe4), .busy(b4));
  uart_rx #(.WIDTH(8), .CLKS_PER_BIT(16)) dut16 (
    .clk(clk), .rst(rst), .rx_in(rx_line), .data_out(d16), .valid(v16),
    .parity_err(pe16), .frame_err(fe16), .busy(b16));

  int sel  = 1;
  int nclk = 1;
  int checks   = 0;
  int failures = 0;

  logic [9:0] q1[$];
  logic [9:0] q4[$];
  logic [9:0] q16[$];

  logic [7:0] o_d;
  logic       o_v, o_pe, o_fe, o_b;

  // Record every received word as {frame_err, parity_err, data}.
  always @(negedge clk) begin
    if (v1)  q1.push_back({fe1, pe1, d1});
    if (v4)  q4.push_back({fe4, pe4, d4});
    if (v16) q16.push_back({fe16, pe16, d16});
  end

  always_comb begin
    o_d = d1; o_v = v1; o_pe = pe1; o_fe = fe1; o_b = b1;
    case (sel)
      4:       begin o_d = d4;  o_v = v4;  o_pe = pe4;  o_fe = fe4;  o_b = b4;  end
      16:      begin o_d = d16; o_v = v16; o_pe = pe16; o_fe = fe16; o_b = b16; end
      default: begin o_d = d1;  o_v = v1;  o_pe = pe1;  o_fe = fe1;  o_b = b1;  end
    endcase
  end

  function automatic int qsize();
    if (sel == 4) return q4.size();
    else if (sel == 16) return q16.size();
    else return q1.size();
  endfunction

  function automatic logic [9:0] qget(input int i);
    if (sel == 4) return q4[i];
    else if (sel == 16) return q16[i];
    else return q1[i];
  endfunction

  function automatic logic [9:0] rec(input logic fe, input logic pe, input logic [7:0] d);
    return {fe, pe, d};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (sel=%0d t=%0t)", tag, got, exp, sel, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rx_line = b;
    tick(nclk);
  endtask

  task automatic send_frame(input logic [7:0] w, input logic par, input logic stp);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      send_bit(w[i]);
      if (i == 3) check_eq("busy_mid", 32'(o_b), 32'd1);
    end
    send_bit(par);
    send_bit(stp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx_line = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(3);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int bcnt;
    logic [7:0] w;
    logic [7:0] exp_w[256];

    rst = 1'b1;
    rx_line = 1'b1;
    tick(3);
    for (int s = 0; s < 3; s++) begin
      sel = (s == 0) ? 1 : ((s == 1) ? 4 : 16);
      #1;
      check_eq("rst_data", 32'(o_d), 32'd0);
      check_eq("rst_valid", 32'(o_v), 32'd0);
      check_eq("rst_perr", 32'(o_pe), 32'd0);
      check_eq("rst_ferr", 32'(o_fe), 32'd0);
      check_eq("rst_busy", 32'(o_b), 32'd0);
    end
    sel = 1; nclk = 1;
    rst = 1'b0;
    tick(3);

    // 0xA5 at one clock per bit: valid exactly three cycles after the stop bit.
    base = qsize();
    send_frame(8'hA5, 1'b0, 1'b1);
    rx_line = 1'b1;
    check_eq("lat_s1_valid", 32'(o_v), 32'd0);
    tick(1);
    check_eq("lat_s2_valid", 32'(o_v), 32'd0);
    check_eq("lat_s2_busy", 32'(o_b), 32'd1);
    tick(1);
    check_eq("lat_s3_valid", 32'(o_v), 32'd1);
    check_eq("a5_data", 32'(o_d), 32'hA5);
    check_eq("a5_perr", 32'(o_pe), 32'd0);
    check_eq("a5_ferr", 32'(o_fe), 32'd0);
    tick(1);
    check_eq("lat_s4_valid", 32'(o_v), 32'd0);
    check_eq("lat_s4_busy", 32'(o_b), 32'd0);
    tick(3);
    check_eq("a5_count", 32'(qsize()), 32'(base + 1));

    // 0x01 with a wrong parity bit.
    base = qsize();
    send_frame(8'h01, 1'b0, 1'b1);
    rx_line = 1'b1;
    tick(5);
    check_eq("perr_count", 32'(qsize()), 32'(base + 1));
    check_eq("perr_rec", 32'(qget(base)), 32'(rec(1'b0, 1'b1, 8'h01)));

    // 0xFF with stop bit 0, line then held low: one frame_err, then silence.
    base = qsize();
    send_frame(8'hFF, 1'b0, 1'b0);
    rx_line = 1'b0;
    tick(4);
    check_eq("ferr_count", 32'(qsize()), 32'(base + 1));
    check_eq("ferr_rec", 32'(qget(base)), 32'(rec(1'b1, 1'b0, 8'hFF)));
    bcnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (o_b) bcnt++;
    end
    check_eq("low_busy_cycles", 32'(bcnt), 32'd0);
    check_eq("low_no_valid", 32'(qsize()), 32'(base + 1));
    rx_line = 1'b1;
    tick(3);
    send_frame(8'h3C, 1'b0, 1'b1);
    rx_line = 1'b1;
    tick(5);
    check_eq("rearm_count", 32'(qsize()), 32'(base + 2));
    check_eq("rearm_rec", 32'(qget(base + 1)), 32'(rec(1'b0, 1'b0, 8'h3C)));

    // Four clocks per bit: a one-cycle low glitch is rejected in START.
    do_reset();
    sel = 4; nclk = 4;
    base = qsize();
    send_frame(8'h96, 1'b0, 1'b1);
    rx_line = 1'b1;
    tick(12);
    check_eq("c4_rec", 32'(qget(base)), 32'(rec(1'b0, 1'b0, 8'h96)));
    base = qsize();
    rx_line = 1'b0;
    tick(1);
    rx_line = 1'b1;
    bcnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (o_b) bcnt++;
    end
    check_eq("glitch_busy_cycles", 32'(bcnt), 32'd1);
    check_eq("glitch_no_valid", 32'(qsize()), 32'(base));
    check_eq("glitch_data_held", 32'(o_d), 32'h96);

    // Back-to-back 0x3C, 0xC3 with no idle gap.
    for (int s = 0; s < 2; s++) begin
      do_reset();
      sel = (s == 0) ? 1 : 16;
      nclk = sel;
      base = qsize();
      send_frame(8'h3C, 1'b0, 1'b1);
      send_frame(8'hC3, 1'b0, 1'b1);
      rx_line = 1'b1;
      tick(2 * nclk + 6);
      check_eq("b2b_count", 32'(qsize()), 32'(base + 2));
      check_eq("b2b_rec0", 32'(qget(base)), 32'(rec(1'b0, 1'b0, 8'h3C)));
      check_eq("b2b_rec1", 32'(qget(base + 1)), 32'(rec(1'b0, 1'b0, 8'hC3)));
    end

    // Loopback: 256 random words sent back-to-back with correct framing.
    do_reset();
    sel = 1; nclk = 1;
    base = qsize();
    for (int i = 0; i < 256; i++) begin
      w = 8'($urandom);
      exp_w[i] = w;
      send_frame(w, ^w, 1'b1);
    end
    rx_line = 1'b1;
    tick(6);
    check_eq("loop_count", 32'(qsize()), 32'(base + 256));
    if (qsize() == base + 256) begin
      for (int i = 0; i < 256; i++) begin
        check_eq("loop_rec", 32'(qget(base + i)), 32'(rec(1'b0, 1'b0, exp_w[i])));
      end
    end

    // Reset while data bit 3 is on the line: partial frame discarded.
    base = qsize();
    w = 8'h77;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(w[i]);
    rx_line = w[3];
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    rx_line = 1'b1;
    tick(6);
    check_eq("midrst_no_valid", 32'(qsize()), 32'(base));
    check_eq("midrst_data", 32'(o_d), 32'd0);
    check_eq("midrst_busy", 32'(o_b), 32'd0);
    send_frame(8'h5A, 1'b0, 1'b1);
    rx_line = 1'b1;
    tick(5);
    check_eq("after_rst_count", 32'(qsize()), 32'(base + 1));
    check_eq("after_rst_rec", 32'(qget(base)), 32'(rec(1'b0, 1'b0, 8'h5A)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
